// File: rtl/gd_multistart_sched.sv
// Multi-start sweep controller: runs the GD core NUM_STARTS times from a diagonal grid and keeps the global minimum.
// Optional early exit on a good-enough minimum is enabled by defining GD_SWEEP_EARLY_EXIT_EN.
module gd_multistart_sched #(
  parameter int                 NUM_STARTS     = 16,
  parameter logic signed [7:0]  START_VAL      = 8'sh00,
  parameter logic signed [7:0]  STEP           = 8'sh01,
  parameter int                 TIMEOUT_CYCLES = 4096,
  parameter logic signed [31:0] EXIT_THRESH    = 32'sh0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sweep_start,
  output logic               sweep_busy,
  output logic               sweep_done,
  output logic               core_rst_n,
  output logic               core_start_op,
  output logic signed [7:0]  core_a,
  output logic signed [7:0]  core_b,
  output logic signed [7:0]  core_c,
  output logic signed [7:0]  core_d,
  input  logic               core_done_op,
  input  logic signed [31:0] core_z_min,
  input  logic signed [7:0]  core_fa,
  input  logic signed [7:0]  core_fb,
  input  logic signed [7:0]  core_fc,
  input  logic signed [7:0]  core_fd,
  output logic signed [31:0] best_z,
  output logic signed [7:0]  best_a,
  output logic signed [7:0]  best_b,
  output logic signed [7:0]  best_c,
  output logic signed [7:0]  best_d,
  output logic [7:0]         best_idx,
  output logic [7:0]         run_count,
  output logic               timeout_err
);

  localparam int                 TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]         K_LAST   = 8'(NUM_STARTS - 1);
  localparam logic signed [31:0] Z_INIT   = 32'sh7FFF_FFFF;

`ifdef GD_SWEEP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_CAPTURE, S_CLEAR, S_NEXT, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         k_q, k_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               core_rst_n_q, core_rst_n_d;
  logic               core_start_op_q, core_start_op_d;
  logic signed [7:0]  core_pt_q, core_pt_d;
  logic signed [31:0] best_z_q, best_z_d;
  logic signed [7:0]  best_a_q, best_a_d;
  logic signed [7:0]  best_b_q, best_b_d;
  logic signed [7:0]  best_c_q, best_c_d;
  logic signed [7:0]  best_d_q, best_d_d;
  logic [7:0]         best_idx_q, best_idx_d;
  logic [7:0]         run_count_q, run_count_d;
  logic               timeout_err_q, timeout_err_d;
  logic               sweep_busy_q, sweep_busy_d;
  logic               sweep_done_q, sweep_done_d;
  logic               exit_q, exit_d;
  logic               exit_hit;

  // Folds to 0 when early exit is compiled out, leaving the sweep length fixed.
  assign exit_hit = EARLY_EXIT && (core_z_min <= EXIT_THRESH);

  always_comb begin
    state_d         = state_q;
    k_d             = k_q;
    tmo_d           = tmo_q;
    core_rst_n_d    = core_rst_n_q;
    core_start_op_d = core_start_op_q;
    core_pt_d       = core_pt_q;
    best_z_d        = best_z_q;
    best_a_d        = best_a_q;
    best_b_d        = best_b_q;
    best_c_d        = best_c_q;
    best_d_d        = best_d_q;
    best_idx_d      = best_idx_q;
    run_count_d     = run_count_q;
    timeout_err_d   = timeout_err_q;
    sweep_busy_d    = sweep_busy_q;
    sweep_done_d    = 1'b0;
    exit_d          = exit_q;

    case (state_q)
      S_IDLE: begin
        core_rst_n_d    = 1'b0;
        core_start_op_d = 1'b0;
        sweep_busy_d    = 1'b0;
        if (sweep_start) begin
          best_z_d      = Z_INIT;
          best_a_d      = '0;
          best_b_d      = '0;
          best_c_d      = '0;
          best_d_d      = '0;
          best_idx_d    = '0;
          run_count_d   = '0;
          timeout_err_d = 1'b0;
          exit_d        = 1'b0;
          k_d           = '0;
          core_pt_d     = START_VAL;
          sweep_busy_d  = 1'b1;
          state_d       = S_LOAD;
        end
      end
      S_LOAD: begin
        core_rst_n_d    = 1'b1;
        core_start_op_d = 1'b0;
        tmo_d           = '0;
        state_d         = S_RUN;
      end
      S_RUN: begin
        core_start_op_d = 1'b1;
        tmo_d           = tmo_q + 1'b1;
        if (core_done_op) begin
          state_d = S_CAPTURE;
        end else if (tmo_q == TMO_LAST) begin
          // Abandoned run: no capture, but it still counts as a completed run.
          timeout_err_d = 1'b1;
          run_count_d   = run_count_q + 8'd1;
          state_d       = S_CLEAR;
        end
      end
      S_CAPTURE: begin
        if (core_z_min < best_z_q) begin
          best_z_d   = core_z_min;
          best_a_d   = core_fa;
          best_b_d   = core_fb;
          best_c_d   = core_fc;
          best_d_d   = core_fd;
          best_idx_d = k_q;
        end
        if (exit_hit) begin
          exit_d = 1'b1;
        end
        run_count_d = run_count_q + 8'd1;
        state_d     = S_CLEAR;
      end
      S_CLEAR: begin
        core_start_op_d = 1'b0;
        core_rst_n_d    = 1'b0;
        if (!core_done_op) begin
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (exit_q || (k_q == K_LAST)) begin
          state_d = S_DONE;
        end else begin
          k_d       = k_q + 8'd1;
          core_pt_d = core_pt_q + STEP;
          state_d   = S_LOAD;
        end
      end
      S_DONE: begin
        sweep_done_d = 1'b1;
        sweep_busy_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      k_q             <= '0;
      tmo_q           <= '0;
      core_rst_n_q    <= 1'b0;
      core_start_op_q <= 1'b0;
      core_pt_q       <= START_VAL;
      best_z_q        <= Z_INIT;
      best_a_q        <= '0;
      best_b_q        <= '0;
      best_c_q        <= '0;
      best_d_q        <= '0;
      best_idx_q      <= '0;
      run_count_q     <= '0;
      timeout_err_q   <= 1'b0;
      sweep_busy_q    <= 1'b0;
      sweep_done_q    <= 1'b0;
      exit_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      k_q             <= k_d;
      tmo_q           <= tmo_d;
      core_rst_n_q    <= core_rst_n_d;
      core_start_op_q <= core_start_op_d;
      core_pt_q       <= core_pt_d;
      best_z_q        <= best_z_d;
      best_a_q        <= best_a_d;
      best_b_q        <= best_b_d;
      best_c_q        <= best_c_d;
      best_d_q        <= best_d_d;
      best_idx_q      <= best_idx_d;
      run_count_q     <= run_count_d;
      timeout_err_q   <= timeout_err_d;
      sweep_busy_q    <= sweep_busy_d;
      sweep_done_q    <= sweep_done_d;
      exit_q          <= exit_d;
    end
  end

  assign sweep_busy    = sweep_busy_q;
  assign sweep_done    = sweep_done_q;
  assign core_rst_n    = core_rst_n_q;
  assign core_start_op = core_start_op_q;
  assign core_a        = core_pt_q;
  assign core_b        = core_pt_q;
  assign core_c        = core_pt_q;
  assign core_d        = core_pt_q;
  assign best_z        = best_z_q;
  assign best_a        = best_a_q;
  assign best_b        = best_b_q;
  assign best_c        = best_c_q;
  assign best_d        = best_d_q;
  assign best_idx      = best_idx_q;
  assign run_count     = run_count_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_gd_multistart_sched.sv
// Directed bench for gd_multistart_sched with a behavioural core: done after 3 start cycles, z from a per-run table.
module tb_gd_multistart_sched;

  localparam int                NS   = 4;
  localparam logic signed [7:0] SV   = 8'sh7E;
  localparam logic signed [7:0] STP  = 8'sh01;
  localparam int                TMO  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sweep_start = 1'b0;
  logic        sweep_busy, sweep_done, core_rst_n, core_start_op;
  logic [7:0]  core_a, core_b, core_c, core_d;
  logic        core_done_op;
  logic [31:0] core_z_min;
  logic [7:0]  core_fa, core_fb, core_fc, core_fd;
  logic [31:0] best_z;
  logic [7:0]  best_a, best_b, best_c, best_d, best_idx, run_count;
  logic        timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gd_multistart_sched #(
    .NUM_STARTS(NS), .START_VAL(SV), .STEP(STP),
    .TIMEOUT_CYCLES(TMO), .EXIT_THRESH(32'sh0000_0000)
  ) dut (
    .clk(clk), .rst(rst), .sweep_start(sweep_start),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .core_rst_n(core_rst_n), .core_start_op(core_start_op),
    .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_d(core_d),
    .core_done_op(core_done_op), .core_z_min(core_z_min),
    .core_fa(core_fa), .core_fb(core_fb), .core_fc(core_fc), .core_fd(core_fd),
    .best_z(best_z), .best_a(best_a), .best_b(best_b), .best_c(best_c), .best_d(best_d),
    .best_idx(best_idx), .run_count(run_count), .timeout_err(timeout_err)
  );

  // Behavioural core model
  logic [31:0] ztab [0:7];
  int          hang_run = -1;
  logic [3:0]  mcnt;
  logic [2:0]  mrun;
  logic        mprev;

  always @(posedge clk) begin
    if (!core_rst_n) mcnt <= 4'd0;
    else if (core_start_op && mcnt != 4'hF) mcnt <= mcnt + 4'd1;
    mprev <= core_rst_n;
    if (!sweep_busy) mrun <= 3'd0;
    else if (mprev && !core_rst_n) mrun <= mrun + 3'd1;
  end

  assign core_done_op = core_rst_n && (mcnt >= 4'd3) && (int'(mrun) != hang_run);
  assign core_z_min   = ztab[mrun];
  assign core_fa      = 8'h10 + {5'b0, mrun};
  assign core_fb      = 8'h20 + {5'b0, mrun};
  assign core_fc      = 8'h30 + {5'b0, mrun};
  assign core_fd      = 8'h40 + {5'b0, mrun};

  // Monitor: per-run core_a at start_op rise, start_op high length, sweep_done pulse count
  logic       mon_clr = 1'b0;
  int         nrun, cur_len, done_pulses;
  logic       so_prev;
  logic [7:0] rec_a   [0:7];
  int         rec_len [0:7];

  always @(posedge clk) begin
    if (mon_clr) begin
      nrun = 0; cur_len = 0; done_pulses = 0; so_prev = 1'b0;
    end else begin
      if (sweep_done) done_pulses++;
      if (core_start_op) begin
        if (!so_prev) begin
          rec_a[nrun[2:0]] = core_a;
          cur_len = 0;
        end
        cur_len++;
      end else if (so_prev) begin
        rec_len[nrun[2:0]] = cur_len;
        nrun++;
      end
      so_prev = core_start_op;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (sweep_done) seen = 1'b1;
    end
    chk(tag, {31'b0, seen}, 32'd1);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic load_z(input logic [31:0] z0, input logic [31:0] z1,
                        input logic [31:0] z2, input logic [31:0] z3);
    ztab[0] = z0; ztab[1] = z1; ztab[2] = z2; ztab[3] = z3;
    for (int i = 4; i < 8; i++) ztab[i] = 32'h0000_7000;
  endtask

  initial begin
    load_z(32'h300, 32'h100, 32'h200, 32'h100);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    chk("rst_start_op",   {31'b0, core_start_op}, 32'd0);
    chk("rst_core_a",     {24'b0, core_a}, 32'h7E);
    chk("rst_core_d",     {24'b0, core_d}, 32'h7E);
    chk("rst_best_z",     best_z, 32'h7FFF_FFFF);
    chk("rst_best_a",     {24'b0, best_a}, 32'h0);
    chk("rst_best_idx",   {24'b0, best_idx}, 32'h0);
    chk("rst_run_count",  {24'b0, run_count}, 32'h0);
    chk("rst_timeout",    {31'b0, timeout_err}, 32'd0);
    chk("rst_busy",       {31'b0, sweep_busy}, 32'd0);
    chk("rst_done",       {31'b0, sweep_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // T1/T2: min tracking with tie, wrap of core_a, start latency
    clear_mon();
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    chk("lat_busy",      {31'b0, sweep_busy}, 32'd1);
    chk("lat_rst_n_lo",  {31'b0, core_rst_n}, 32'd0);
    @(negedge clk);
    chk("lat_rst_n_hi",  {31'b0, core_rst_n}, 32'd1);
    chk("lat_start_lo",  {31'b0, core_start_op}, 32'd0);
    @(negedge clk);
    chk("lat_start_hi",  {31'b0, core_start_op}, 32'd1);
    wait_done(600, "t1_done_seen");
    chk("t1_busy_low",   {31'b0, sweep_busy}, 32'd0);
    chk("t1_run_count",  {24'b0, run_count}, 32'd4);
    chk("t1_best_z",     best_z, 32'h100);
    chk("t1_best_idx",   {24'b0, best_idx}, 32'd1);
    chk("t1_best_a",     {24'b0, best_a}, 32'h11);
    chk("t1_best_b",     {24'b0, best_b}, 32'h21);
    chk("t1_best_c",     {24'b0, best_c}, 32'h31);
    chk("t1_best_d",     {24'b0, best_d}, 32'h41);
    chk("t1_timeout",    {31'b0, timeout_err}, 32'd0);
    chk("t2_core_a_r0",  {24'b0, rec_a[0]}, 32'h7E);
    chk("t2_core_a_r1",  {24'b0, rec_a[1]}, 32'h7F);
    chk("t2_core_a_r2",  {24'b0, rec_a[2]}, 32'h80);
    chk("t2_core_a_r3",  {24'b0, rec_a[3]}, 32'h81);
    chk("t1_run0_len",   rec_len[0], 32'd6);
    repeat (5) @(negedge clk);
    chk("t1_done_pulses", done_pulses, 32'd1);
    chk("t1_best_hold",  best_z, 32'h100);
    chk("t1_idle_busy",  {31'b0, sweep_busy}, 32'd0);

    // T3: run 2 never finishes -> timeout after 16 RUN cycles, no capture
    load_z(32'h300, 32'h200, 32'h80, 32'h250);
    hang_run = 2;
    clear_mon();
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    chk("t3_reinit_z",   best_z, 32'h7FFF_FFFF);
    chk("t3_reinit_cnt", {24'b0, run_count}, 32'd0);
    wait_done(800, "t3_done_seen");
    chk("t3_timeout",    {31'b0, timeout_err}, 32'd1);
    chk("t3_run_count",  {24'b0, run_count}, 32'd4);
    chk("t3_best_z",     best_z, 32'h200);
    chk("t3_best_idx",   {24'b0, best_idx}, 32'd1);
    chk("t3_run2_len",   rec_len[2], 32'd16);
    chk("t3_run3_len",   rec_len[3], 32'd6);
    hang_run = -1;

    // T4: reset asserted while run 1 is in RUN
    load_z(32'h300, 32'h100, 32'h200, 32'h100);
    clear_mon();
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
        @(negedge clk);
        if (nrun == 1 && core_start_op) hit = 1'b1;
      end
      chk("t4_reached_run1", {31'b0, hit}, 32'd1);
    end
    chk("t4_pre_best_z", best_z, 32'h300);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_n",      {31'b0, core_rst_n}, 32'd0);
    chk("t4_start_op",   {31'b0, core_start_op}, 32'd0);
    chk("t4_best_z",     best_z, 32'h7FFF_FFFF);
    chk("t4_busy",       {31'b0, sweep_busy}, 32'd0);
    chk("t4_run_count",  {24'b0, run_count}, 32'd0);
    chk("t4_core_a",     {24'b0, core_a}, 32'h7E);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t4_stay_idle",  {31'b0, sweep_busy}, 32'd0);
    chk("t4_rst_n_idle", {31'b0, core_rst_n}, 32'd0);

    // T5: sweep_start held high -> back-to-back sweeps, one per IDLE visit
    clear_mon();
    sweep_start = 1'b1;
    @(negedge clk);
    chk("t5_busy_1",     {31'b0, sweep_busy}, 32'd1);
    wait_done(600, "t5_done1_seen");
    @(negedge clk);
    chk("t5_restart",    {31'b0, sweep_busy}, 32'd1);
    chk("t5_done_low",   {31'b0, sweep_done}, 32'd0);
    chk("t5_cnt_reinit", {24'b0, run_count}, 32'd0);
    wait_done(600, "t5_done2_seen");
    sweep_start = 1'b0;
    chk("t5_run_count",  {24'b0, run_count}, 32'd4);
    chk("t5_best_z",     best_z, 32'h100);
    repeat (3) @(negedge clk);
    chk("t5_busy_end",   {31'b0, sweep_busy}, 32'd0);
    chk("t5_pulses",     done_pulses, 32'd2);

`ifdef GD_SWEEP_EARLY_EXIT_EN
    // T6: z <= threshold in run 1 ends the sweep early
    load_z(32'h40, 32'hFFFF_FF00, 32'h10, 32'h10);
    clear_mon();
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    wait_done(600, "t6_done_seen");
    chk("t6_run_count",  {24'b0, run_count}, 32'd2);
    chk("t6_best_idx",   {24'b0, best_idx}, 32'd1);
    chk("t6_best_z",     best_z, 32'hFFFF_FF00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
